// File: rtl/stage_fetch_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package stage_fetch_pkg;

   localparam logic [31:0] NOP_WORD     = 32'h0000_0000;
   localparam logic [31:0] HALT_WORD    = 32'hFFFF_FFFF;
   localparam logic [31:0] PC_RESET_VEC = 32'h0000_0000;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } fetch_state_e;

   function automatic logic [31:0] jump_to_byte(input logic [31:0] word_idx);
      return word_idx << 2;
   endfunction

endpackage

// File: rtl/stage_fetch_if.sv
// Fetch -> decode boundary: IF/ID latch contents out, hazard-unit write enables in.
interface stage_fetch_if;
   logic [31:0] o_pc;
   logic [31:0] o_instruction;
   logic        is_pc_write;
   logic        is_write_IF_ID;

   modport master (
      output o_pc,
      output o_instruction,
      input  is_pc_write,
      input  is_write_IF_ID
   );

   modport slave (
      input  o_pc,
      input  o_instruction,
      output is_pc_write,
      output is_write_IF_ID
   );
endinterface

// File: rtl/stage_fetch_instruction_memory.sv
// Word-addressed instruction store: one synchronous write port, one async read port.
module instruction_memory #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [31:0]       wdata_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [31:0]       rdata_o
);

   logic [31:0] mem_q [0:(1<<ADDR_W)-1];

   // No reset: contents survive a pipeline reset so the debug loader runs once.
   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/stage_fetch.sv
// MIPS instruction-fetch stage with IF/ID latch, redirect handling and halt detection.
//
// state   | meaning
// ST_RUN  | fetching normally, cycle counter running
// ST_HALT | halt word latched; PC frozen, IF/ID drains NOPs until a redirect
module stage_fetch
   import stage_fetch_pkg::*;
#(
   parameter int          IMEM_ADDR_W = 8,
   parameter logic [31:0] HALT_INSTR  = HALT_WORD,
   parameter logic [31:0] NOP_INSTR   = NOP_WORD
) (
   input  logic                   clk,
   input  logic                   i_rst_n,
   input  logic                   i_enable,
   input  logic                   is_branch_taken,
   input  logic [31:0]            i_branch_target,
   input  logic                   is_jump,
   input  logic [31:0]            i_jump_address,
   input  logic                   i_imem_wr_en,
   input  logic [IMEM_ADDR_W-1:0] i_imem_wr_addr,
   input  logic [31:0]            i_imem_wr_data,
   stage_fetch_if.master          dec_if,
   output logic [31:0]            o_pc_current,
   output logic                   o_halt,
   output logic [31:0]            o_cycle_count
);

   logic [31:0]  pc_q;
   logic [31:0]  if_pc_q;
   logic [31:0]  if_instr_q;
   logic [31:0]  cycle_q;
   fetch_state_e state_q;

   logic [31:0]  fetch_word;
   logic [31:0]  pc_plus4;
   logic [31:0]  jump_target;
   logic         halt_fetch;

   instruction_memory #(.ADDR_W(IMEM_ADDR_W)) u_imem (
      .clk     (clk),
      .we_i    (i_imem_wr_en),
      .waddr_i (i_imem_wr_addr),
      .wdata_i (i_imem_wr_data),
      .raddr_i (pc_q[IMEM_ADDR_W+1:2]),
      .rdata_o (fetch_word)
   );

   assign pc_plus4    = pc_q + 32'd4;
   assign jump_target = jump_to_byte(i_jump_address);
   // A halt word is only taken when the hazard unit lets it advance.
   assign halt_fetch  = (fetch_word == HALT_INSTR) && dec_if.is_pc_write
                        && dec_if.is_write_IF_ID;

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         pc_q       <= PC_RESET_VEC;
         if_pc_q    <= '0;
         if_instr_q <= NOP_INSTR;
         cycle_q    <= '0;
         state_q    <= ST_RUN;
      end else if (i_enable) begin
         if (state_q == ST_RUN) cycle_q <= cycle_q + 32'd1;

         if (is_jump) begin
            pc_q       <= jump_target;
            if_pc_q    <= '0;
            if_instr_q <= NOP_INSTR;
            state_q    <= ST_RUN;
         end else if (is_branch_taken) begin
            // Redirects beat stalls and cancel a halt fetched on the wrong path.
            pc_q       <= i_branch_target;
            if_pc_q    <= '0;
            if_instr_q <= NOP_INSTR;
            state_q    <= ST_RUN;
         end else if (state_q == ST_HALT) begin
            if_pc_q    <= '0;
            if_instr_q <= NOP_INSTR;
         end else if (halt_fetch) begin
            if_pc_q    <= pc_plus4;
            if_instr_q <= HALT_INSTR;
            state_q    <= ST_HALT;
         end else begin
            if (dec_if.is_pc_write) pc_q <= pc_plus4;
            if (dec_if.is_write_IF_ID) begin
               if_pc_q    <= pc_plus4;
               if_instr_q <= fetch_word;
            end
         end
      end
   end

   assign dec_if.o_pc          = if_pc_q;
   assign dec_if.o_instruction = if_instr_q;
   assign o_pc_current         = pc_q;
   assign o_halt               = (state_q == ST_HALT);
   assign o_cycle_count        = cycle_q;

endmodule

// File: tb/tb_stage_fetch.sv
// Table-driven bench for stage_fetch with an expected-result queue.
module tb_stage_fetch;

   logic        clk = 1'b0;
   logic        i_rst_n;
   logic        i_enable;
   logic        is_branch_taken;
   logic [31:0] i_branch_target;
   logic        is_jump;
   logic [31:0] i_jump_address;
   logic        i_imem_wr_en;
   logic [7:0]  i_imem_wr_addr;
   logic [31:0] i_imem_wr_data;
   logic [31:0] o_pc_current;
   logic        o_halt;
   logic [31:0] o_cycle_count;

   stage_fetch_if ifc();

   stage_fetch dut (
      .clk             (clk),
      .i_rst_n         (i_rst_n),
      .i_enable        (i_enable),
      .is_branch_taken (is_branch_taken),
      .i_branch_target (i_branch_target),
      .is_jump         (is_jump),
      .i_jump_address  (i_jump_address),
      .i_imem_wr_en    (i_imem_wr_en),
      .i_imem_wr_addr  (i_imem_wr_addr),
      .i_imem_wr_data  (i_imem_wr_data),
      .dec_if          (ifc),
      .o_pc_current    (o_pc_current),
      .o_halt          (o_halt),
      .o_cycle_count   (o_cycle_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        en, pw, wi, br, jmp, we;
      logic [31:0] bt, ja, wd;
      logic [7:0]  wa;
      logic [31:0] e_pc_cur, e_opc, e_instr, e_cnt;
      logic        e_halt;
   } vec_t;

   typedef struct {
      logic [31:0] pc_cur, opc, instr, cnt;
      logic        halt;
      int          idx;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [31:0] pc_cur, input logic [31:0] opc,
                          input logic [31:0] instr, input logic halt, input logic [31:0] cnt);
      chk({tag, " pc_current"}, o_pc_current, pc_cur);
      chk({tag, " o_pc"}, ifc.o_pc, opc);
      chk({tag, " o_instruction"}, ifc.o_instruction, instr);
      chk({tag, " o_halt"}, {31'd0, o_halt}, {31'd0, halt});
      chk({tag, " cycle_count"}, o_cycle_count, cnt);
   endtask

   function automatic vec_t mk(input logic en, input logic pw, input logic wi,
                               input logic br, input logic [31:0] bt,
                               input logic jmp, input logic [31:0] ja,
                               input logic we, input logic [7:0] wa, input logic [31:0] wd,
                               input logic [31:0] pcc, input logic [31:0] opc,
                               input logic [31:0] ins, input logic h, input logic [31:0] cnt);
      vec_t v;
      v.en = en; v.pw = pw; v.wi = wi; v.br = br; v.bt = bt; v.jmp = jmp; v.ja = ja;
      v.we = we; v.wa = wa; v.wd = wd;
      v.e_pc_cur = pcc; v.e_opc = opc; v.e_instr = ins; v.e_halt = h; v.e_cnt = cnt;
      return v;
   endfunction

   task automatic load(input logic [7:0] a, input logic [31:0] d);
      @(negedge clk);
      i_imem_wr_en = 1'b1; i_imem_wr_addr = a; i_imem_wr_data = d;
      @(negedge clk);
      i_imem_wr_en = 1'b0;
   endtask

   initial begin
      exp_t e;
      i_rst_n = 1'b0; i_enable = 1'b0;
      is_branch_taken = 1'b0; i_branch_target = '0;
      is_jump = 1'b0; i_jump_address = '0;
      i_imem_wr_en = 1'b0; i_imem_wr_addr = '0; i_imem_wr_data = '0;
      ifc.is_pc_write = 1'b1; ifc.is_write_IF_ID = 1'b1;

      load(8'd0,   32'h2001_0005);
      load(8'd1,   32'h2002_0007);
      load(8'd2,   32'h0000_0000);
      load(8'd3,   32'h2003_000A);
      load(8'd4,   32'hFFFF_FFFF);
      load(8'd16,  32'h1111_1111);
      load(8'd32,  32'h2222_2222);
      load(8'd255, 32'h3333_3333);

      #1 chk_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);

      //           en pw wi br bt         jmp ja            we wa     wd            pc_cur        o_pc          instr         h  cnt
      vecs.push_back(mk(1,1,1,0,32'h0,     0,32'h0,        0,8'd0,  32'h0,        32'h4,        32'h4,        32'h2001_0005,0,32'd1));
      vecs.push_back(mk(1,1,1,0,32'h0,     0,32'h0,        0,8'd0,  32'h0,        32'h8,        32'h8,        32'h2002_0007,0,32'd2));
      vecs.push_back(mk(1,0,0,0,32'h0,     0,32'h0,        0,8'd0,  32'h0,        32'h8,        32'h8,        32'h2002_0007,0,32'd3));
      vecs.push_back(mk(1,1,1,0,32'h0,     0,32'h0,        0,8'd0,  32'h0,        32'hC,        32'hC,        32'h0,        0,32'd4));
      vecs.push_back(mk(1,0,0,1,32'h40,    0,32'h0,        0,8'd0,  32'h0,        32'h40,       32'h0,        32'h0,        0,32'd5));
      vecs.push_back(mk(1,1,1,0,32'h0,     0,32'h0,        0,8'd0,  32'h0,        32'h44,       32'h44,       32'h1111_1111,0,32'd6));
      vecs.push_back(mk(1,1,1,1,32'h80,    1,32'h3,        0,8'd0,  32'h0,        32'hC,        32'h0,        32'h0,        0,32'd7));
      vecs.push_back(mk(1,1,1,0,32'h0,     0,32'h0,        0,8'd0,  32'h0,        32'h10,       32'h10,       32'h2003_000A,0,32'd8));
      vecs.push_back(mk(1,1,1,0,32'h0,     0,32'h0,        0,8'd0,  32'h0,        32'h10,       32'h14,       32'hFFFF_FFFF,1,32'd9));
      vecs.push_back(mk(1,1,1,0,32'h0,     0,32'h0,        0,8'd0,  32'h0,        32'h10,       32'h0,        32'h0,        1,32'd9));
      vecs.push_back(mk(1,1,1,0,32'h0,     0,32'h0,        0,8'd0,  32'h0,        32'h10,       32'h0,        32'h0,        1,32'd9));
      vecs.push_back(mk(1,1,1,1,32'h0,     0,32'h0,        0,8'd0,  32'h0,        32'h0,        32'h0,        32'h0,        0,32'd9));
      vecs.push_back(mk(1,1,1,0,32'h0,     0,32'h0,        0,8'd0,  32'h0,        32'h4,        32'h4,        32'h2001_0005,0,32'd10));
      vecs.push_back(mk(0,1,1,1,32'h80,    1,32'h7,        1,8'd1,  32'h0BAD_F00D,32'h4,        32'h4,        32'h2001_0005,0,32'd10));
      vecs.push_back(mk(1,1,1,0,32'h0,     1,32'h3FFF_FFFF,0,8'd0,  32'h0,        32'hFFFF_FFFC,32'h0,        32'h0,        0,32'd11));
      vecs.push_back(mk(1,1,1,0,32'h0,     0,32'h0,        0,8'd0,  32'h0,        32'h0,        32'h0,        32'h3333_3333,0,32'd12));
      vecs.push_back(mk(1,1,1,0,32'h0,     0,32'h0,        1,8'd0,  32'hDEAD_BEEF,32'h4,        32'h4,        32'h2001_0005,0,32'd13));
      vecs.push_back(mk(1,1,1,0,32'h0,     1,32'h0,        0,8'd0,  32'h0,        32'h0,        32'h0,        32'h0,        0,32'd14));
      vecs.push_back(mk(1,1,1,0,32'h0,     0,32'h0,        0,8'd0,  32'h0,        32'h4,        32'h4,        32'hDEAD_BEEF,0,32'd15));
      vecs.push_back(mk(1,1,1,0,32'h0,     0,32'h0,        0,8'd0,  32'h0,        32'h8,        32'h8,        32'h0BAD_F00D,0,32'd16));

      @(negedge clk);
      i_rst_n = 1'b1;

      foreach (vecs[i]) begin
         @(negedge clk);
         i_enable = vecs[i].en;
         ifc.is_pc_write = vecs[i].pw; ifc.is_write_IF_ID = vecs[i].wi;
         is_branch_taken = vecs[i].br; i_branch_target = vecs[i].bt;
         is_jump = vecs[i].jmp; i_jump_address = vecs[i].ja;
         i_imem_wr_en = vecs[i].we; i_imem_wr_addr = vecs[i].wa; i_imem_wr_data = vecs[i].wd;
         e.pc_cur = vecs[i].e_pc_cur; e.opc = vecs[i].e_opc; e.instr = vecs[i].e_instr;
         e.halt = vecs[i].e_halt; e.cnt = vecs[i].e_cnt; e.idx = i;
         sb.push_back(e);
         @(posedge clk);
         #1;
         if (sb.size() == 0) begin
            bad++; total++;
            $display("FAIL scoreboard empty at vec %0d", i);
         end else begin
            e = sb.pop_front();
            chk_all($sformatf("vec%0d", e.idx), e.pc_cur, e.opc, e.instr, e.halt, e.cnt);
         end
      end

      // Disabled with noisy redirect inputs: everything must stay put.
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         i_enable = 1'b0; i_imem_wr_en = 1'b0;
         is_jump = 1'($urandom_range(0, 1)); i_jump_address = $urandom;
         is_branch_taken = 1'($urandom_range(0, 1)); i_branch_target = $urandom;
         ifc.is_pc_write = 1'($urandom_range(0, 1)); ifc.is_write_IF_ID = 1'($urandom_range(0, 1));
         @(posedge clk);
         #1 chk_all($sformatf("frozen%0d", k), 32'h8, 32'h8, 32'h0BAD_F00D, 1'b0, 32'd16);
      end

      @(negedge clk);
      i_enable = 1'b1; is_jump = 1'b0; is_branch_taken = 1'b0;
      #2 i_rst_n = 1'b0;
      #1 chk_all("async_rst", 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
